fsic_wb_cfg_seq: RTL and testbench
==================================

# fsic_wb_cfg_seq

Synthesizable Wishbone master that replays a programmable table of register accesses into the FSIC `wbs_*` slave port after reset or on demand. It sits directly upstream of FSIC and takes over the `wbs_adr/wbs_wdata/wbs_sel/wbs_cyc/wbs_stb/wbs_we` inputs that are otherwise tied idle. It lets the FSIC configuration bring-up run in hardware: sequenced writes, optional reads and completion status.

## Interface
- pDEPTH, 8, number of table entries (2..64)
- pDATA_WIDTH, 32, Wishbone data width
- pTIMEOUT, 255, max cycles waiting for `wbs_ack` (timeout build only)

- wb_clk  in  1  sole clock, all logic rising-edge
- wb_rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(pDEPTH)  table entry index
- cfg_addr  in  32  entry address
- cfg_data  in  pDATA_WIDTH  entry write data
- cfg_sel  in  4  entry byte select
- cfg_wr  in  1  entry type: 1 = write, 0 = read
- cfg_count  in  $clog2(pDEPTH)+1  entries to run, sampled on `start`
- start  in  1  single-cycle launch pulse
- wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we  out  32/pDATA_WIDTH/4/1/1/1  Wishbone master to FSIC
- wbs_ack  in  1  slave acknowledge
- wbs_rdata  in  pDATA_WIDTH  slave read data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  sticky timeout flag, cleared by `start`
- last_rdata  out  pDATA_WIDTH  data captured on the most recent read ack

## Operation
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- Table writes:
  - `cfg_we` in IDLE writes entry `cfg_idx`.
  - `cfg_we` is ignored in any other state.
- Launch:
  - `start` in IDLE latches n = min(`cfg_count`, pDEPTH).
  - Clears idx and `err`.
  - Goes to ISSUE if n > 0, else straight to DONE with no bus cycle.
  - `start` outside IDLE is ignored.
- ISSUE:
  - Drives entry[idx] onto `wbs_adr/wbs_wdata/wbs_sel/wbs_we`.
  - Asserts `wbs_cyc` = `wbs_stb` = 1.
  - Moves to WAIT.
- WAIT:
  - Holds the bus stable until `wbs_ack` is sampled high.
  - On that edge: drops `cyc/stb`; if `wbs_we` = 0, captures `wbs_rdata` into `last_rdata`; increments idx.
  - Next state is GAP if idx < n, else DONE.
- GAP: one idle bus cycle, then ISSUE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `wbs_ack` while `wbs_stb` = 0 is ignored.
- `busy` = 1 in ISSUE, WAIT, GAP and DONE.
- Outputs are registered. `wbs_adr/wdata/sel/we` hold their last value when idle.
- Reset (also mid-transaction):
  - All outputs go to 0 immediately. `cyc/stb` deassert asynchronously.
  - State goes to IDLE; idx and n go to 0; `last_rdata` goes to 0.
  - Table contents are not reset.

## Timing
- `start` sampled at edge T → `wbs_cyc/stb` high from T+1.
- Ack sampled at edge A → `cyc/stb` low from A+1.
  - Next entry's `cyc/stb` high from A+2.
  - After the last entry, `done` is high during A+1.
- Per entry: 2 + ack latency cycles.
  - Zero-wait slave: ack the cycle `stb` rises.
  - n entries: `done` at T + 2n.
- A read's data is visible on `last_rdata` from A+1.

## Configuration
- `FSIC_WBSEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `wbs_ack` is still low after pTIMEOUT cycles: drop `cyc/stb`, set `err` = 1, abort the remaining entries, go to DONE (`done` pulses).
  - A simultaneous ack on the expiry cycle counts as success.
- Not defined:
  - WAIT waits indefinitely.
  - `err` is tied to 0.
  - No counter logic exists.

## Structure
- Package `fsic_wbseq_pkg` holds:
  - state enum `wbseq_state_e`;
  - `wbseq_entry_t` struct {addr[31:0], data, sel[3:0], wr};
  - default pTIMEOUT constant.
- Sub-module `fsic_wbseq_table`: pDEPTH × `wbseq_entry_t` register file with one write port and one asynchronous read port.
- FSM, counters and bus registers live in the top.

## Test plan
- Zero-wait slave, 3 writes to 0x3000_0000/04/08 with data 0x11/0x22/0x33, sel 0xF → three single-cycle-ack transactions one gap apart, `done` at T+6, `err` = 0.
- Slave with ack 4 cycles after `stb`, entry 1 a read returning 0xDEAD_BEEF → `cyc/stb` held stable 5 cycles, `wbs_we` = 0, `last_rdata` = 0xDEAD_BEEF from A+1.
- `cfg_count` = 0 → no `cyc`; `done` at T+1. `cfg_count` = 9 with pDEPTH = 8 → exactly 8 transactions.
- `start` and `cfg_we` pulsed during WAIT → no restart, table unchanged, sequence completes normally.
- `wb_rst` asserted mid-WAIT → `cyc/stb/busy` low without waiting for a clock edge. After release, `start` replays from entry 0 with the retained table.
- Timeout build with pTIMEOUT = 16 and a slave that never acks, 3 entries → `cyc` drops after 16 cycles, `err` = 1, `done` pulses, entries 1–2 never issued. Next `start` clears `err`.

Source files
------------

// File: rtl/fsic_wbseq_pkg.sv
// Shared types for the FSIC Wishbone configuration sequencer: FSM states,
// table entry layout and the default ack timeout.
package fsic_wbseq_pkg;

  // Entry data is stored at the widest supported bus width; the top slices it.
  localparam int WBSEQ_MAX_DW      = 64;
  localparam int WBSEQ_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } wbseq_state_e;

  typedef struct packed {
    logic [31:0]             addr;
    logic [WBSEQ_MAX_DW-1:0] data;
    logic [3:0]              sel;
    logic                    wr;
  } wbseq_entry_t;

endpackage

// File: rtl/fsic_wbseq_table.sv
// Access table for the sequencer: one synchronous write port, one
// asynchronous read port. Contents survive reset.
module fsic_wbseq_table
  import fsic_wbseq_pkg::*;
#(
  parameter int pDEPTH = 8
) (
  input  logic                      wb_clk,
  input  logic                      i_we,
  input  logic [$clog2(pDEPTH)-1:0] i_widx,
  input  wbseq_entry_t              i_wentry,
  input  logic [$clog2(pDEPTH)-1:0] i_ridx,
  output wbseq_entry_t              o_rentry
);

  wbseq_entry_t r_mem [pDEPTH];

  always_ff @(posedge wb_clk) begin
    if (i_we) r_mem[i_widx] <= i_wentry;
  end

  assign o_rentry = r_mem[i_ridx];

endmodule

// File: rtl/fsic_wb_cfg_seq.sv
// Wishbone master replaying a programmed access table into the FSIC wbs_* port.
// Optional ack timeout: define FSIC_WBSEQ_TIMEOUT_EN.
module fsic_wb_cfg_seq
  import fsic_wbseq_pkg::*;
#(
  parameter int pDEPTH      = 8,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = WBSEQ_TIMEOUT_DEF
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic                      cfg_we,
  input  logic [$clog2(pDEPTH)-1:0] cfg_idx,
  input  logic [31:0]               cfg_addr,
  input  logic [pDATA_WIDTH-1:0]    cfg_data,
  input  logic [3:0]                cfg_sel,
  input  logic                      cfg_wr,
  input  logic [$clog2(pDEPTH):0]   cfg_count,
  input  logic                      start,
  output logic [31:0]               wbs_adr,
  output logic [pDATA_WIDTH-1:0]    wbs_wdata,
  output logic [3:0]                wbs_sel,
  output logic                      wbs_cyc,
  output logic                      wbs_stb,
  output logic                      wbs_we,
  input  logic                      wbs_ack,
  input  logic [pDATA_WIDTH-1:0]    wbs_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [pDATA_WIDTH-1:0]    last_rdata
);

  localparam int IW = $clog2(pDEPTH);
  localparam int CW = IW + 1;

  wbseq_state_e           r_state;
  logic [CW-1:0]          r_idx, r_n;
  logic [31:0]            r_adr;
  logic [pDATA_WIDTH-1:0] r_wdata, r_last;
  logic [3:0]             r_sel;
  logic                   r_we, r_cyc, r_stb, r_busy, r_done;

  wbseq_entry_t  w_wentry, w_rentry;
  logic [CW-1:0] w_n_start, w_idx_nxt;
  logic [IW-1:0] w_ridx;
  logic          w_launch, w_ack, w_load, w_timeout;
  logic          w_unused_data;

  always_comb begin
    w_wentry                        = '0;
    w_wentry.addr                   = cfg_addr;
    w_wentry.data[pDATA_WIDTH-1:0]  = cfg_data;
    w_wentry.sel                    = cfg_sel;
    w_wentry.wr                     = cfg_wr;
  end

  // Idle reads entry 0 so a launch can load the bus on the start edge itself.
  assign w_ridx    = (r_state == S_IDLE) ? '0 : r_idx[IW-1:0];
  assign w_n_start = (cfg_count > CW'(pDEPTH)) ? CW'(pDEPTH) : cfg_count;
  assign w_launch  = (r_state == S_IDLE) && start;
  assign w_ack     = wbs_ack && r_stb;
  assign w_idx_nxt = r_idx + CW'(1);
  assign w_load    = (w_launch && (w_n_start != '0)) || (r_state == S_GAP);
  assign w_unused_data = ^w_rentry.data;

  fsic_wbseq_table #(.pDEPTH(pDEPTH)) u_table (
    .wb_clk   (wb_clk),
    .i_we     (cfg_we && (r_state == S_IDLE)),
    .i_widx   (cfg_idx),
    .i_wentry (w_wentry),
    .i_ridx   (w_ridx),
    .o_rentry (w_rentry)
  );

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else if (w_load) begin
      r_adr   <= w_rentry.addr;
      r_wdata <= w_rentry.data[pDATA_WIDTH-1:0];
      r_sel   <= w_rentry.sel;
      r_we    <= w_rentry.wr;
    end
  end

  // ISSUE is the first bus cycle of an access; an ack there is honoured too.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n    <= w_n_start;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (w_n_start != '0) begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_idx <= w_idx_nxt;
            if (!r_we) r_last <= wbs_rdata;
            if (w_idx_nxt < r_n) begin
              r_state <= S_GAP;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_timeout) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_GAP: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FSIC_WBSEQ_TIMEOUT_EN
  localparam int TW = $clog2(pTIMEOUT + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // An ack arriving on the expiry cycle wins over the timeout.
  assign w_timeout = r_stb && !wbs_ack && (r_to_cnt == TW'(pTIMEOUT - 1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_stb && !wbs_ack && !w_timeout) r_to_cnt <= r_to_cnt + TW'(1);
      else                                 r_to_cnt <= '0;
      if (w_launch)       r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = (pTIMEOUT == 0);
  assign w_timeout   = 1'b0;
  assign err         = 1'b0;
`endif

  assign wbs_adr    = r_adr;
  assign wbs_wdata  = r_wdata;
  assign wbs_sel    = r_sel;
  assign wbs_we     = r_we;
  assign wbs_cyc    = r_cyc;
  assign wbs_stb    = r_stb;
  assign busy       = r_busy;
  assign done       = r_done;
  assign last_rdata = r_last;

endmodule

// File: tb/tb_fsic_wb_cfg_seq.sv
// Bench for fsic_wb_cfg_seq: scenario table, hand-written corner sequences and
// randomized tables checked against a transaction-level model.
module tb_fsic_wb_cfg_seq;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic [31:0]   cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [3:0]    cfg_sel = '0;
  logic          cfg_wr = 1'b0;
  logic [3:0]    cfg_count = '0;
  logic          start = 1'b0;
  logic [31:0]   wbs_adr;
  logic [DW-1:0] wbs_wdata;
  logic [3:0]    wbs_sel;
  logic          wbs_cyc, wbs_stb, wbs_we, wbs_ack;
  logic [DW-1:0] wbs_rdata;
  logic          busy, done, err;
  logic [DW-1:0] last_rdata;

  fsic_wb_cfg_seq #(.pDEPTH(DEPTH), .pDATA_WIDTH(DW), .pTIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_sel(cfg_sel), .cfg_wr(cfg_wr),
    .cfg_count(cfg_count), .start(start), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata),
    .wbs_sel(wbs_sel), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata), .busy(busy), .done(done), .err(err),
    .last_rdata(last_rdata)
  );

  always #5 wb_clk = ~wb_clk;

  // Slave: acks s_lat cycles after stb rises; read data derived from address.
  int          s_lat = 0;
  logic        s_never = 1'b0;
  logic [31:0] s_rbase = 32'h5A5A_0000;
  int          s_cnt = 0;
  always @(posedge wb_clk) begin
    if (!wbs_stb || wbs_ack) s_cnt <= 0;
    else                     s_cnt <= s_cnt + 1;
  end
  assign wbs_ack   = wbs_stb && !s_never && (s_cnt == s_lat);
  assign wbs_rdata = wbs_adr ^ s_rbase;

  int cyc_n = 0;
  always @(posedge wb_clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    int          rise;
    int          ack;
  } txn_t;

  txn_t        txn_q[$];
  int          done_q[$];
  logic [31:0] ld_hist [int];
  int          rise_n = 0, cyc_hi = 0, stab_err = 0, cur_rise = 0;
  logic        p_cyc = 1'b0, p_ack = 1'b0;
  logic [68:0] p_bus = '0;

  always @(negedge wb_clk) begin
    if (wbs_cyc) cyc_hi++;
    if (wbs_cyc && !p_cyc) begin cur_rise = cyc_n; rise_n++; end
    if (wbs_cyc && p_cyc && !p_ack && ({wbs_adr, wbs_wdata, wbs_sel, wbs_we} != p_bus)) stab_err++;
    if (wbs_cyc && wbs_stb && wbs_ack) txn_q.push_back('{wbs_adr, wbs_wdata, wbs_sel, wbs_we, cur_rise, cyc_n});
    if (done) done_q.push_back(cyc_n);
    ld_hist[cyc_n] = last_rdata;
    p_cyc = wbs_cyc;
    p_ack = wbs_ack;
    p_bus = {wbs_adr, wbs_wdata, wbs_sel, wbs_we};
  end

  // Reference model: the programmed table and the last read result.
  logic [31:0] m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  logic [3:0]  m_sel  [DEPTH];
  logic        m_wr   [DEPTH];
  logic [31:0] m_last = '0;

  int checks = 0, errors = 0;
  int t0 = 0, b_txn = 0, b_done = 0, b_rise = 0, b_stab = 0, b_hi = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wr_entry(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic w);
    @(negedge wb_clk);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d; cfg_sel = s; cfg_wr = w;
    @(negedge wb_clk);
    cfg_we = 1'b0;
    m_addr[idx] = a; m_data[idx] = d; m_sel[idx] = s; m_wr[idx] = w;
  endtask

  task automatic run(input int count, input int lat);
    s_lat = lat;
    @(negedge wb_clk); #1;
    b_txn = txn_q.size(); b_done = done_q.size(); b_rise = rise_n; b_stab = stab_err; b_hi = cyc_hi;
    cfg_count = 4'(count); start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0; t0 = cyc_n;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (done_q.size() > b_done) ok = 1;
      else @(negedge wb_clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout actual=no_done expected=done"); end
    repeat (3) @(negedge wb_clk);
    #1;
  endtask

  task automatic check_run(input int n, input int lat, input int off);
    int nt;
    nt = txn_q.size() - b_txn;
    chk("txn_count", 128'(nt), 128'(n));
    chk("cyc_rises", 128'(rise_n - b_rise), 128'(n));
    for (int k = 0; k < n && k < nt; k++) begin
      chk("txn_adr_wdata", {txn_q[b_txn+k].adr, txn_q[b_txn+k].wdata}, {m_addr[k], m_data[k]});
      chk("txn_sel_we", {txn_q[b_txn+k].sel, txn_q[b_txn+k].we}, {m_sel[k], m_wr[k]});
      chk("txn_rise", 128'(txn_q[b_txn+k].rise - t0), 128'(k * (2 + lat)));
      if (!m_wr[k]) m_last = m_addr[k] ^ s_rbase;
    end
    chk("done_pulses", 128'(done_q.size() - b_done), 128'(1));
    if (done_q.size() > b_done) chk("done_cycle", 128'(done_q[b_done] - t0), 128'(off));
    chk("bus_stable", 128'(stab_err - b_stab), 128'(0));
    chk("err", 128'(err), 128'(0));
    chk("busy_after", 128'(busy), 128'(0));
    chk("last_rdata", 128'(last_rdata), 128'(m_last));
  endtask

  typedef struct {
    int count;
    int lat;
    int exp_n;
    int exp_off;
  } scen_t;
  scen_t sc [6];

  initial begin
    logic [31:0] prev;
    int a, cnt, lat, n;

    // Offsets are in bench cycles: first bus cycle of the run is offset 0.
    sc[0] = '{3, 0, 3, 5};
    sc[1] = '{2, 4, 2, 11};
    sc[2] = '{0, 0, 0, 0};
    sc[3] = '{9, 0, 8, 15};
    sc[4] = '{8, 1, 8, 23};
    sc[5] = '{1, 2, 1, 3};

    #12;
    chk("rst_cyc_stb", {wbs_cyc, wbs_stb}, 2'b00);
    chk("rst_busy_done_err", {busy, done, err}, 3'b000);
    chk("rst_bus", {wbs_adr, wbs_sel, wbs_we}, '0);
    chk("rst_last_rdata", 128'(last_rdata), '0);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    wr_entry(0, 32'h3000_0000, 32'h11, 4'hF, 1'b1);
    wr_entry(1, 32'h3000_0004, 32'h22, 4'hF, 1'b1);
    wr_entry(2, 32'h3000_0008, 32'h33, 4'hF, 1'b1);
    for (int i = 3; i < DEPTH; i++)
      wr_entry(i, 32'h3000_0100 + 32'(i * 4), 32'h100 + 32'(i), 4'(i), (i != 5));

    for (int s = 0; s < 6; s++) begin
      run(sc[s].count, sc[s].lat);
      if (sc[s].exp_n == 0) chk("no_cyc_on_zero", 128'(wbs_cyc), '0);
      wait_done(200);
      check_run(sc[s].exp_n, sc[s].lat, sc[s].exp_off);
    end

    // Slow read returning 0xDEADBEEF as entry 1.
    wr_entry(1, 32'h3000_0004, 32'h0, 4'hF, 1'b0);
    s_rbase = 32'hDEAD_BEEF ^ 32'h3000_0004;
    prev = m_last;
    run(2, 4);
    wait_done(200);
    a = txn_q[b_txn+1].ack;
    chk("rd_hold_cycles", 128'(a - txn_q[b_txn+1].rise), 128'(4));
    chk("rd_before_ack", 128'(ld_hist[a]), 128'(prev));
    chk("rd_after_ack", 128'(ld_hist[a+1]), 128'(32'hDEAD_BEEF));
    check_run(2, 4, 11);

    // start and cfg_we during WAIT are ignored.
    run(3, 6);
    repeat (2) @(negedge wb_clk);
    start = 1'b1; cfg_count = 4'd1;
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_addr = 32'hBAD0_0000; cfg_data = 32'hBAD; cfg_sel = 4'h1; cfg_wr = 1'b0;
    @(negedge wb_clk);
    start = 1'b0; cfg_we = 1'b0;
    wait_done(200);
    check_run(3, 6, 23);

    // Asynchronous reset in the middle of a WAIT.
    run(3, 10);
    repeat (3) @(negedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    chk("async_rst_cyc_stb_busy", {wbs_cyc, wbs_stb, busy}, 3'b000);
    chk("async_rst_last_rdata", 128'(last_rdata), '0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    m_last = '0;
    run(3, 0);
    wait_done(200);
    check_run(3, 0, 5);

`ifdef FSIC_WBSEQ_TIMEOUT_EN
    s_never = 1'b1;
    run(3, 0);
    wait_done(200);
    chk("to_txn_count", 128'(txn_q.size() - b_txn), '0);
    chk("to_cyc_rises", 128'(rise_n - b_rise), 128'(1));
    chk("to_cyc_high", 128'(cyc_hi - b_hi), 128'(16));
    chk("to_done_cycle", 128'(done_q[b_done] - t0), 128'(16));
    chk("to_done_pulses", 128'(done_q.size() - b_done), 128'(1));
    chk("to_err_set", 128'(err), 128'(1));
    s_never = 1'b0;
    run(1, 0);
    chk("to_err_cleared", 128'(err), '0);
    wait_done(200);
    check_run(1, 0, 1);
`endif

    // Randomized tables, counts and slave latency.
    for (int r = 0; r < 5; r++) begin
      s_rbase = $urandom;
      for (int i = 0; i < DEPTH; i++)
        wr_entry(i, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cnt = $urandom_range(0, 9);
      lat = $urandom_range(0, 3);
      n   = (cnt > DEPTH) ? DEPTH : cnt;
      run(cnt, lat);
      wait_done(300);
      check_run(n, lat, (n == 0) ? 0 : n * (2 + lat) - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
